// File: rtl/instruction_memory_sync.sv
// RAM-backed instruction store. It clears every word to RESET_FILL after reset,
// then serves one-cycle fetches and accepts word writes from the program loader.
module instruction_memory_sync #(
    parameter int                 ADDR_BITS  = 8,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  RESET_FILL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault,
    input  logic              prog_we,
    input  logic [31:0]       prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ack
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0]     fetch_instr_q, fetch_instr_d;
    logic                  fetch_fault_q, fetch_fault_d;
    logic                  prog_ack_q, prog_ack_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;

    logic [ADDR_BITS-1:0]  fetch_idx, prog_idx;
    logic                  fetch_legal, prog_legal;

    // Legal means word-aligned and no address bits above the array depth.
    assign fetch_idx   = fetch_addr[ADDR_BITS+1:2];
    assign prog_idx    = prog_addr[ADDR_BITS+1:2];
    assign fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:ADDR_BITS+2] == '0);
    assign prog_legal  = (prog_addr[1:0] == 2'b00) && (prog_addr[31:ADDR_BITS+2] == '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        fetch_fault_d = fetch_fault_q;
        prog_ack_d    = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = cnt_q;
        mem_wdata     = RESET_FILL;

        if (reset) begin
            state_d       = INIT;
            cnt_d         = '0;
            fetch_instr_d = '0;
            fetch_fault_d = 1'b0;
        end else if (state_q == INIT) begin
            mem_we = 1'b1;
            // The counter parks on the last index so it never wraps back into a clear.
            if (cnt_q == '1) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (prog_we && prog_legal) begin
                mem_we     = 1'b1;
                mem_waddr  = prog_idx;
                mem_wdata  = prog_data;
                prog_ack_d = 1'b1;
            end
            if (fetch_req) begin
                fetch_valid_d = 1'b1;
                if (fetch_legal) begin
                    fetch_fault_d = 1'b0;
                    // Write-first: a same-edge load to this index is returned directly.
                    fetch_instr_d = (mem_we && (mem_waddr == fetch_idx)) ? mem_wdata
                                                                         : mem[fetch_idx];
                end else begin
                    fetch_fault_d = 1'b1;
                    fetch_instr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            fetch_fault_q <= 1'b0;
            prog_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
            prog_ack_q    <= prog_ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready       = (state_q == RUN);
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;
    assign prog_ack    = prog_ack_q;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync: fetch results and load acks are
// queued with the cycle they are due and matched by a negedge monitor.
module tb_instruction_memory_sync;
    logic        clk;
    logic        reset;
    logic        ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_ack;

    instruction_memory_sync dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_ack    (prog_ack)
    );

    typedef struct {
        int          due;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t fq[$];
    int   aq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (fq.size() > 0 && fq[0].due == cyc) begin
                check("fetch_valid", {31'd0, fetch_valid}, 32'd1);
                check("fetch_instr", fetch_instr, fq[0].instr);
                check("fetch_fault", {31'd0, fetch_fault}, {31'd0, fq[0].fault});
                void'(fq.pop_front());
            end else begin
                check("fetch_valid_idle", {31'd0, fetch_valid}, 32'd0);
            end
            if (aq.size() > 0 && aq[0] == cyc) begin
                check("prog_ack", {31'd0, prog_ack}, 32'd1);
                void'(aq.pop_front());
            end else begin
                check("prog_ack_idle", {31'd0, prog_ack}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input logic fault);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        e.due = cyc + 1; e.instr = instr; e.fault = fault;
        fq.push_back(e);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data, input bit acked);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        if (acked) aq.push_back(cyc + 1);
        tick();
        prog_we = 1'b0;
    endtask

    // Reset has just been released before the edge that follows; ready must stay
    // low for 255 more edges and rise on the 256th.
    task automatic wait_init();
        for (int i = 1; i < 256; i++) begin
            tick();
            check("ready_init", {31'd0, ready}, 32'd0);
        end
        tick();
        check("ready_run", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        exp_t e;
        reset = 1; fetch_req = 0; fetch_addr = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        tick();
        mon_en = 1;
        tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_instr", fetch_instr, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_ack",   {31'd0, prog_ack}, 32'd0);
        reset = 0;
        wait_init();

        // Cleared array, first and last word.
        fetch(32'h000, 32'h0, 1'b0);
        fetch(32'h3FC, 32'h0, 1'b0);
        tick();

        // Program load, then back-to-back fetches.
        write(32'h000, 32'h20042f5b, 1'b1);
        write(32'h004, 32'h2405cfc7, 1'b1);
        write(32'h02C, 32'h0800000b, 1'b1);
        fetch(32'h000, 32'h20042f5b, 1'b0);
        fetch(32'h004, 32'h2405cfc7, 1'b0);
        fetch(32'h02C, 32'h0800000b, 1'b0);
        tick();

        // Illegal addresses; outputs hold while idle.
        fetch(32'h002, 32'h0, 1'b1);
        fetch(32'h400, 32'h0, 1'b1);
        tick();
        check("hold_fault", {31'd0, fetch_fault}, 32'd1);
        check("hold_instr", fetch_instr, 32'd0);
        write(32'h001, 32'hffffffff, 1'b0);
        fetch(32'h000, 32'h20042f5b, 1'b0);
        tick();

        // Same-edge write and fetch: write-first.
        prog_we = 1; prog_addr = 32'h010; prog_data = 32'h00c44020;
        fetch_req = 1; fetch_addr = 32'h010;
        aq.push_back(cyc + 1);
        e.due = cyc + 1; e.instr = 32'h00c44020; e.fault = 1'b0;
        fq.push_back(e);
        tick();
        prog_we = 0; fetch_req = 0;
        fetch(32'h010, 32'h00c44020, 1'b0);
        tick();

        // Reset lands on the edge that samples a fetch: no result comes back.
        fetch_req = 1; fetch_addr = 32'h000; reset = 1;
        tick();
        fetch_req = 0; reset = 0;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_instr", fetch_instr, 32'd0);
        wait_init();
        fetch(32'h000, 32'h0, 1'b0);
        tick();

        // Requests held through INIT are ignored until ready is up.
        write(32'h000, 32'h20042f5b, 1'b1);
        reset = 1;
        tick();
        reset = 0;
        fetch_req = 1; fetch_addr = 32'h000;
        prog_we = 1; prog_addr = 32'h000; prog_data = 32'hdeadbeef;
        wait_init();
        prog_we = 0;
        fetch(32'h000, 32'h0, 1'b0);
        tick();
        tick();

        check("fetch_q_empty", fq.size(), 32'd0);
        check("ack_q_empty",   aq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
